// File: rtl/lsu_dmem_port.sv
// MEM-stage load/store unit. It runs one request/acknowledge data-bus
// transaction per accepted access and stalls the pipeline while it is in
// flight. The unit generates store byte enables and replicated store lanes,
// and it sign- or zero-extends load data. Illegal requests, misaligned
// requests and bus timeouts each raise a one-cycle error pulse.
module lsu_dmem_port #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        Dmem_wr_en,
    input  logic        Dmem_rd_en,
    input  logic [1:0]  MemWrite,
    input  logic [2:0]  MemRead,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    output logic        lsu_stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  load_rd,
    output logic        misaligned,
    output logic        fault,
    output logic [31:0] err_addr,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b011,
        LD_HU = 3'b100
    } load_kind_t;

    state_t      state, state_d;
    logic [7:0]  wait_cnt;
    logic [1:0]  off_q;
    load_kind_t  kind_q;
    logic [4:0]  rd_q;
    logic [31:0] addr_q;

    logic        go, illegal, misal, accept, err_illegal, err_misal;
    logic        is_half, is_word, timeout;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Request classification: legality, access size, alignment.
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (Dmem_wr_en) begin
            is_half = (MemWrite == 2'b10);
            is_word = (MemWrite == 2'b11);
        end else if (Dmem_rd_en) begin
            is_half = (MemRead == LD_H) || (MemRead == LD_HU);
            is_word = (MemRead == LD_W);
        end
        illegal = (Dmem_wr_en & Dmem_rd_en)
                | (Dmem_wr_en & (MemWrite == 2'b00))
                | (Dmem_rd_en & (MemRead > 3'b100));
        misal   = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    end

    // Store lane replication and byte enables.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        case (MemWrite)
            2'b01: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b10: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata;
            end
        endcase
    end

    // Load extraction from the latched byte offset and load kind.
    always_comb begin
        byte_sel = dbus_rdata[7:0];
        case (off_q)
            2'd0:    byte_sel = dbus_rdata[7:0];
            2'd1:    byte_sel = dbus_rdata[15:8];
            2'd2:    byte_sel = dbus_rdata[23:16];
            default: byte_sel = dbus_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (kind_q)
            LD_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext_data = {24'h000000, byte_sel};
            LD_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext_data = {16'h0000, half_sel};
            default: ext_data = dbus_rdata;
        endcase
    end

    // Next-state logic and the combinational stall.
    always_comb begin
        state_d     = state;
        go          = 1'b0;
        accept      = 1'b0;
        err_illegal = 1'b0;
        err_misal   = 1'b0;
        timeout     = 1'b0;
        case (state)
            // ABORT is the fault-pulse cycle; a new request may be taken in it
            // so that back-to-back issue after a timeout loses no cycle.
            S_IDLE, S_ABORT: begin
                go          = mem_valid & (Dmem_wr_en | Dmem_rd_en);
                err_illegal = go & illegal;
                err_misal   = go & ~illegal & misal;
                accept      = go & ~illegal & ~misal;
                state_d     = accept ? S_BUSY : S_IDLE;
            end
            S_BUSY: begin
                timeout = ~dbus_ack & (wait_cnt == 8'(MAX_WAIT - 1));
                if (dbus_ack) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    state_d = S_ABORT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        lsu_stall = ~rst & (accept | (state == S_BUSY));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Bus outputs, request context, wait counter and result/error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= '0;
            off_q      <= '0;
            kind_q     <= LD_W;
            rd_q       <= '0;
            addr_q     <= '0;
            load_valid <= 1'b0;
            load_data  <= '0;
            load_rd    <= '0;
            misaligned <= 1'b0;
            fault      <= 1'b0;
            err_addr   <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= '0;
            dbus_wdata <= '0;
        end else begin
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            fault      <= 1'b0;
            if (accept) begin
                dbus_req   <= 1'b1;
                dbus_we    <= Dmem_wr_en;
                dbus_addr  <= {addr[31:2], 2'b00};
                dbus_be    <= Dmem_wr_en ? be_d : 4'b0000;
                dbus_wdata <= Dmem_wr_en ? wdata_d : '0;
                wait_cnt   <= '0;
                off_q      <= addr[1:0];
                kind_q     <= load_kind_t'(MemRead);
                rd_q       <= rd_in;
                addr_q     <= addr;
            end
            if (err_illegal) begin
                fault    <= 1'b1;
                err_addr <= addr;
            end
            if (err_misal) begin
                misaligned <= 1'b1;
                err_addr   <= addr;
            end
            if (state == S_BUSY) begin
                if (dbus_ack) begin
                    dbus_req <= 1'b0;
                    if (!dbus_we) begin
                        load_valid <= 1'b1;
                        load_data  <= ext_data;
                        load_rd    <= rd_q;
                    end
                end else if (timeout) begin
                    dbus_req <= 1'b0;
                    fault    <= 1'b1;
                    err_addr <= addr_q;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port with a load-result scoreboard.
module tb_lsu_dmem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, Dmem_wr_en, Dmem_rd_en;
    logic [1:0]  MemWrite;
    logic [2:0]  MemRead;
    logic [31:0] addr, wdata;
    logic [4:0]  rd_in;
    logic        lsu_stall, load_valid, misaligned, fault;
    logic [31:0] load_data, err_addr;
    logic [4:0]  load_rd;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    lsu_dmem_port #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid),
        .Dmem_wr_en(Dmem_wr_en), .Dmem_rd_en(Dmem_rd_en),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .addr(addr), .wdata(wdata), .rd_in(rd_in),
        .lsu_stall(lsu_stall), .load_valid(load_valid),
        .load_data(load_data), .load_rd(load_rd),
        .misaligned(misaligned), .fault(fault), .err_addr(err_addr),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Scoreboard: every load_valid pulse must match the oldest expected load.
    always @(negedge clk) begin
        if (load_valid === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed load_valid data %h rd %0d expected none", load_data, load_rd);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_load_data", load_data, e.data);
                chk("sb_load_rd", 32'(load_rd), 32'(e.rd));
            end
        end
    end

    task automatic clear_in();
        mem_valid  = 1'b0;
        Dmem_wr_en = 1'b0;
        Dmem_rd_en = 1'b0;
        MemWrite   = 2'b00;
        MemRead    = 3'b000;
        addr       = '0;
        wdata      = '0;
        rd_in      = '0;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [1:0] mw,
                         input logic [2:0] mr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rdi);
        mem_valid  = 1'b1;
        Dmem_wr_en = wr;
        Dmem_rd_en = rd;
        MemWrite   = mw;
        MemRead    = mr;
        addr       = a;
        wdata      = wd;
        rd_in      = rdi;
    endtask

    task automatic do_store(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] wd,
                            input int unsigned ack_at, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        drive(1'b1, 1'b0, mw, 3'b000, a, wd, 5'd0);
        #1 chk1("st_stall_T", lsu_stall, 1'b1);
        step();
        clear_in();
        chk1("st_req", dbus_req, 1'b1);
        chk1("st_we", dbus_we, 1'b1);
        chk("st_addr", dbus_addr, {a[31:2], 2'b00});
        chk("st_be", 32'(dbus_be), 32'(exp_be));
        chk("st_wdata", dbus_wdata, exp_wd);
        for (int i = 1; i < int'(ack_at); i++) begin
            chk1("st_stall_wait", lsu_stall, 1'b1);
            chk1("st_req_wait", dbus_req, 1'b1);
            step();
        end
        dbus_ack = 1'b1;
        #1 chk1("st_stall_ack", lsu_stall, 1'b1);
        step();
        dbus_ack = 1'b0;
        chk1("st_req_done", dbus_req, 1'b0);
        chk1("st_stall_done", lsu_stall, 1'b0);
        chk1("st_no_load_valid", load_valid, 1'b0);
        chk1("st_no_fault", fault, 1'b0);
        step();
    endtask

    task automatic do_load(input logic [2:0] mr, input logic [31:0] a, input logic [4:0] rdi,
                           input logic [31:0] rdata, input int unsigned ack_at,
                           input logic [31:0] exp_data);
        exp_t e;
        e.data = exp_data;
        e.rd   = rdi;
        exp_q.push_back(e);
        drive(1'b0, 1'b1, 2'b00, mr, a, 32'h0, rdi);
        #1 chk1("ld_stall_T", lsu_stall, 1'b1);
        step();
        clear_in();
        chk1("ld_req", dbus_req, 1'b1);
        chk1("ld_we", dbus_we, 1'b0);
        chk("ld_be", 32'(dbus_be), 32'h0);
        chk("ld_addr", dbus_addr, {a[31:2], 2'b00});
        for (int i = 1; i < int'(ack_at); i++) begin
            chk1("ld_stall_wait", lsu_stall, 1'b1);
            chk1("ld_valid_early", load_valid, 1'b0);
            step();
        end
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
        #1 chk1("ld_stall_ack", lsu_stall, 1'b1);
        step();
        dbus_ack   = 1'b0;
        dbus_rdata = '0;
        chk1("ld_valid", load_valid, 1'b1);
        chk1("ld_req_done", dbus_req, 1'b0);
        chk1("ld_stall_done", lsu_stall, 1'b0);
        step();
        chk1("ld_valid_once", load_valid, 1'b0);
    endtask

    task automatic do_err(input logic wr, input logic rd, input logic [1:0] mw,
                          input logic [2:0] mr, input logic [31:0] a,
                          input logic exp_mis, input logic exp_fault);
        drive(wr, rd, mw, mr, a, 32'h12345678, 5'd3);
        #1 chk1("err_no_stall", lsu_stall, 1'b0);
        step();
        clear_in();
        chk1("err_misaligned", misaligned, exp_mis);
        chk1("err_fault", fault, exp_fault);
        chk("err_addr", err_addr, a);
        chk1("err_no_req", dbus_req, 1'b0);
        chk1("err_no_stall_after", lsu_stall, 1'b0);
        step();
        chk1("err_pulse_end", misaligned | fault, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_in();
        dbus_ack   = 1'b0;
        dbus_rdata = '0;
        rst        = 1'b1;
        step();
        step();
        chk1("rst_stall", lsu_stall, 1'b0);
        chk1("rst_req", dbus_req, 1'b0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_dbus_addr", dbus_addr, 32'h0);
        rst = 1'b0;
        step();

        // Stores: lane replication and byte enables.
        do_store(2'b01, 32'h0000_1003, 32'hAABB_CCDD, 1, 4'b1000, 32'hDDDD_DDDD);
        do_store(2'b01, 32'h0000_1000, 32'hAABB_CCDD, 2, 4'b0001, 32'hDDDD_DDDD);
        do_store(2'b10, 32'h0000_2002, 32'h1122_3344, 2, 4'b1100, 32'h3344_3344);
        do_store(2'b10, 32'h0000_2000, 32'h1122_3344, 1, 4'b0011, 32'h3344_3344);
        do_store(2'b11, 32'h0000_3000, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF);

        // Loads: extraction and extension.
        do_load(3'b001, 32'h0000_2002, 5'd5, 32'h12F4_5678, 3, 32'hFFFF_FFF4);
        do_load(3'b011, 32'h0000_2002, 5'd6, 32'h12F4_5678, 3, 32'h0000_00F4);
        do_load(3'b001, 32'h0000_2001, 5'd11, 32'h12F4_5678, 1, 32'h0000_0056);
        do_load(3'b010, 32'h0000_2002, 5'd7, 32'h8001_FFFF, 1, 32'hFFFF_8001);
        do_load(3'b100, 32'h0000_2002, 5'd8, 32'h8001_FFFF, 2, 32'h0000_8001);
        do_load(3'b010, 32'h0000_2000, 5'd9, 32'h8001_FFFF, 1, 32'hFFFF_FFFF);
        do_load(3'b100, 32'h0000_2000, 5'd10, 32'h8001_FFFF, 1, 32'h0000_FFFF);
        do_load(3'b000, 32'h0000_2004, 5'd31, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

        // Misaligned and illegal requests.
        do_err(1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_3002, 1'b1, 1'b0);
        do_err(1'b0, 1'b1, 2'b00, 3'b010, 32'h0000_3001, 1'b1, 1'b0);
        do_err(1'b1, 1'b0, 2'b10, 3'b000, 32'h0000_3003, 1'b1, 1'b0);
        do_err(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_3004, 1'b0, 1'b1);
        do_err(1'b1, 1'b1, 2'b11, 3'b000, 32'h0000_3008, 1'b0, 1'b1);
        do_err(1'b0, 1'b1, 2'b00, 3'b111, 32'h0000_3001, 1'b0, 1'b1);

        // Timeout: sw with no ack and MAX_WAIT = 4.
        drive(1'b1, 1'b0, 2'b11, 3'b000, 32'h0000_4008, 32'h0BAD_F00D, 5'd0);
        #1 chk1("to_stall_T", lsu_stall, 1'b1);
        step();
        clear_in();
        for (int i = 1; i <= 4; i++) begin
            chk1("to_req_held", dbus_req, 1'b1);
            chk1("to_stall_held", lsu_stall, 1'b1);
            chk1("to_no_fault_yet", fault, 1'b0);
            step();
        end
        chk1("to_fault", fault, 1'b1);
        chk("to_err_addr", err_addr, 32'h0000_4008);
        chk1("to_req_dropped", dbus_req, 1'b0);
        chk1("to_stall_low", lsu_stall, 1'b0);
        step();
        chk1("to_fault_once", fault, 1'b0);

        // Ack on the last allowed cycle completes normally.
        do_store(2'b11, 32'h0000_4008, 32'h0BAD_F00D, 4, 4'b1111, 32'h0BAD_F00D);

        // Reset during a pending load, then a stale ack.
        drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_5000, 32'h0, 5'd9);
        step();
        clear_in();
        chk1("rl_req", dbus_req, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("rl_req_cleared", dbus_req, 1'b0);
        chk1("rl_stall_cleared", lsu_stall, 1'b0);
        chk("rl_load_data", load_data, 32'h0);
        chk("rl_err_addr", err_addr, 32'h0);
        chk("rl_dbus_addr", dbus_addr, 32'h0);
        chk("rl_dbus_wdata", dbus_wdata, 32'h0);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h7777_7777;
        #1 chk1("rl_ack_no_stall", lsu_stall, 1'b0);
        step();
        dbus_ack   = 1'b0;
        dbus_rdata = '0;
        chk1("rl_no_load_valid", load_valid, 1'b0);
        chk1("rl_no_fault_a", fault, 1'b0);
        step();
        chk1("rl_no_fault_b", fault, 1'b0);
        step();
        chk1("rl_no_fault_c", fault, 1'b0);

        // Spurious ack in IDLE.
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h5555_AAAA;
        step();
        dbus_ack   = 1'b0;
        dbus_rdata = '0;
        chk1("idle_ack_no_valid", load_valid, 1'b0);
        chk1("idle_ack_no_req", dbus_req, 1'b0);
        step();

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
